// File: rtl/vga_rx_decoder.sv
// ============================================================================
//  Module   : vga_rx_decoder
//  Purpose  : Locks to incoming VGA sync timing and emits X/Y-tagged pixels.
//             Optional per-frame checksum: VGA_RX_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_rx_decoder #(
  parameter int TIMEOUT     = 4095,
  parameter int MIN_H_TOTAL = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  input  logic        iVGA_HS,
  input  logic        iVGA_VS,
  input  logic        iVGA_BLANK_N,
  output logic [9:0]  oR,
  output logic [9:0]  oG,
  output logic [9:0]  oB,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic        oPIX_VALID,
  output logic        oFRAME_START,
  output logic        oLOCKED,
  output logic        oERR,
  output logic [11:0] oH_TOTAL,
  output logic [10:0] oV_TOTAL,
  output logic [31:0] oFRAME_SUM
);

  localparam logic [11:0] c_TMO     = 12'(TIMEOUT);
  localparam logic [12:0] c_MIN_H   = 13'(MIN_H_TOTAL);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_MEAS1  = 2'd1,
    S_MEAS2  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t      r_state;
  logic [9:0]  r_s1_r, r_s1_g, r_s1_b;
  logic        r_s1_hs, r_s1_vs, r_s1_bn;
  logic        r_s2_hs, r_s2_vs, r_s2_bn;
  logic [11:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic [9:0]  r_x, r_y;
  logic [11:0] r_h_meas, r_h_total;
  logic [10:0] r_v_meas, r_v_total;
  logic [9:0]  r_out_r, r_out_g, r_out_b, r_out_x, r_out_y;
  logic        r_pix_valid, r_frame_start, r_err;

  logic        w_hsf, w_vsf, w_bf, w_glitch, w_tmo;
  logic [12:0] w_period;
  logic [10:0] w_vcnt_eff;

  assign w_hsf      = r_s2_hs & ~r_s1_hs;
  assign w_vsf      = r_s2_vs & ~r_s1_vs;
  assign w_bf       = r_s2_bn & ~r_s1_bn;
  // 13-bit period so a saturated hcnt never wraps into a false glitch
  assign w_period   = {1'b0, r_hcnt} + 13'd1;
  assign w_glitch   = w_hsf && (w_period < c_MIN_H);
  assign w_tmo      = (r_hcnt == c_TMO);
  // An HSF coincident with VSF belongs to the frame that is ending
  assign w_vcnt_eff = r_vcnt + {10'd0, w_hsf};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1_r <= '0; r_s1_g <= '0; r_s1_b <= '0;
      r_s1_hs <= 1'b0; r_s1_vs <= 1'b0; r_s1_bn <= 1'b0;
      r_s2_hs <= 1'b0; r_s2_vs <= 1'b0; r_s2_bn <= 1'b0;
      r_hcnt <= '0; r_vcnt <= '0; r_x <= '0; r_y <= '0;
      r_out_r <= '0; r_out_g <= '0; r_out_b <= '0;
      r_out_x <= '0; r_out_y <= '0; r_pix_valid <= 1'b0;
    end else begin
      r_s1_r  <= iVGA_R;  r_s1_g  <= iVGA_G;  r_s1_b  <= iVGA_B;
      r_s1_hs <= iVGA_HS; r_s1_vs <= iVGA_VS; r_s1_bn <= iVGA_BLANK_N;
      r_s2_hs <= r_s1_hs; r_s2_vs <= r_s1_vs; r_s2_bn <= r_s1_bn;
      if (w_hsf)       r_hcnt <= '0;
      else if (!w_tmo) r_hcnt <= r_hcnt + 12'd1;
      if (w_vsf)       r_vcnt <= '0;
      else if (w_hsf)  r_vcnt <= r_vcnt + 11'd1;
      if (w_hsf)        r_x <= '0;
      else if (r_s1_bn) r_x <= r_x + 10'd1;
      if (w_vsf)        r_y <= '0;
      else if (w_bf)    r_y <= r_y + 10'd1;
      r_out_r <= r_s1_r; r_out_g <= r_s1_g; r_out_b <= r_s1_b;
      r_out_x <= r_x;    r_out_y <= r_y;
      r_pix_valid <= (r_state == S_LOCKED) && r_s1_bn;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state       <= S_SEARCH;
      r_h_meas      <= '0;
      r_v_meas      <= '0;
      r_h_total     <= '0;
      r_v_total     <= '0;
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_SEARCH: begin
          if (w_vsf) r_state <= S_MEAS1;
        end
        S_MEAS1: begin
          if (w_glitch || w_tmo) begin
            r_state <= S_SEARCH;
          end else begin
            if (w_hsf) r_h_meas <= w_period[11:0];
            if (w_vsf) begin
              r_v_meas <= w_vcnt_eff;
              r_state  <= S_MEAS2;
            end
          end
        end
        S_MEAS2: begin
          if (w_glitch || w_tmo || (w_hsf && (w_period != {1'b0, r_h_meas}))) begin
            r_state <= S_SEARCH;
          end else if (w_vsf) begin
            if (w_vcnt_eff == r_v_meas) begin
              r_h_total <= r_h_meas;
              r_v_total <= r_v_meas;
              r_state   <= S_LOCKED;
            end else begin
              r_state <= S_SEARCH;
            end
          end
        end
        S_LOCKED: begin
          if (w_glitch || w_tmo ||
              (w_hsf && (w_period != {1'b0, r_h_total})) ||
              (w_vsf && (w_vcnt_eff != r_v_total))) begin
            r_state <= S_SEARCH;
            r_err   <= 1'b1;
          end else if (w_vsf) begin
            r_frame_start <= 1'b1;
          end
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] r_acc, r_sum;
  logic [31:0] w_add;

  assign w_add = r_pix_valid ? (32'(r_out_r) + 32'(r_out_g) + 32'(r_out_b)) : 32'd0;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_acc <= '0;
      r_sum <= '0;
    end else if (w_vsf) begin
      r_sum <= r_acc + w_add;
      r_acc <= '0;
    end else begin
      r_acc <= r_acc + w_add;
    end
  end

  assign oFRAME_SUM = r_sum;
`else
  assign oFRAME_SUM = '0;
`endif

  assign oR           = r_out_r;
  assign oG           = r_out_g;
  assign oB           = r_out_b;
  assign oX           = r_out_x;
  assign oY           = r_out_y;
  assign oPIX_VALID   = r_pix_valid;
  assign oFRAME_START = r_frame_start;
  assign oLOCKED      = (r_state == S_LOCKED);
  assign oERR         = r_err;
  assign oH_TOTAL     = r_h_total;
  assign oV_TOTAL     = r_v_total;

endmodule

`default_nettype wire
